// File: rtl/multicycle_maindec_if.sv
// Memory/instruction handshake between the multi-cycle main decoder and the memory/IR side.
// The decoder drives the memory requests; memory and IR supply mem_ready and the opcode.
interface multicycle_maindec_if #(
    parameter int OPW = 4
) ();
    logic [OPW-1:0] op;
    logic           mem_ready;
    logic           memread;
    logic           memwrite;

    modport master (
        input  op,
        input  mem_ready,
        output memread,
        output memwrite
    );

    modport slave (
        output op,
        output mem_ready,
        input  memread,
        input  memwrite
    );
endinterface

// File: rtl/multicycle_maindec.sv
// Multi-cycle main decoder: Moore FSM sequencing fetch/decode/execute/memory/writeback
// for the 4-bit-opcode CPU, with a fixed-length MULT stall and memory handshaking.
module multicycle_maindec #(
    parameter int OPW         = 4,
    parameter int MULT_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    multicycle_maindec_if.master bus,
    output logic                 pcwrite,
    output logic                 irwrite,
    output logic                 regwrite,
    output logic                 regdst,
    output logic                 alusrc,
    output logic                 mem2reg,
    output logic                 branch,
    output logic                 jump,
    output logic                 jumpreg,
    output logic [1:0]           hilo_sel,
    output logic                 hilo_write,
    output logic                 busy,
    output logic                 illegal,
    output logic [3:0]           state_o
);
    localparam int CW = $clog2(MULT_CYCLES + 1);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC   = 4'd2,
        S_RWB    = 4'd3,
        S_MEMADR = 4'd4,
        S_MEM    = 4'd5,
        S_LWB    = 4'd6,
        S_BRANCH = 4'd7,
        S_JUMP   = 4'd8,
        S_MULT   = 4'd9
    } state_t;

    typedef struct packed {
        logic       pcwrite;
        logic       regwrite;
        logic       regdst;
        logic       alusrc;
        logic       memread;
        logic       memwrite;
        logic       mem2reg;
        logic       branch;
        logic       jump;
        logic       jumpreg;
        logic [1:0] hilo_sel;
        logic       hilo_write;
        logic       busy;
    } ctrl_t;

    state_t        state_r;
    state_t        state_next_s;
    logic [3:0]    op_q_r;
    logic [3:0]    op_q_next_s;
    logic [CW-1:0] count_r;
    logic [CW-1:0] count_next_s;
    ctrl_t         ctrl_r;
    logic          op_hi_s;
    logic          fetch_ack_s;

    function automatic logic [1:0] hilo_for(input logic [3:0] opq);
        logic [1:0] sel;
        case (opq)
            4'h5:    sel = 2'b01;
            4'h6:    sel = 2'b10;
            default: sel = 2'b00;
        endcase
        return sel;
    endfunction

    function automatic ctrl_t moore_ctrl(input state_t st, input logic [3:0] opq,
                                         input logic cnt_zero);
        ctrl_t c;
        c      = '0;
        c.busy = (st != S_FETCH);
        case (st)
            S_FETCH:  c.memread = 1'b1;
            S_DECODE: c.busy = 1'b1;
            S_EXEC: begin
                c.regdst   = 1'b1;
                c.hilo_sel = hilo_for(opq);
            end
            S_RWB: begin
                c.regwrite = 1'b1;
                c.regdst   = 1'b1;
                c.hilo_sel = hilo_for(opq);
            end
            S_MEMADR: c.alusrc = 1'b1;
            S_MEM: begin
                c.alusrc   = 1'b1;
                c.memread  = (opq == 4'h7);
                c.memwrite = (opq == 4'h8);
            end
            S_LWB: begin
                c.regwrite = 1'b1;
                c.mem2reg  = 1'b1;
            end
            S_BRANCH: c.branch = 1'b1;
            S_JUMP: begin
                c.pcwrite = 1'b1;
                c.jump    = (opq == 4'h2);
                c.jumpreg = (opq == 4'h1);
            end
            S_MULT:   c.hilo_write = cnt_zero;
            default:  c = '0;
        endcase
        return c;
    endfunction

    if (OPW > 4) begin : g_wide_op
        assign op_hi_s = |bus.op[OPW-1:4];
    end else begin : g_narrow_op
        assign op_hi_s = 1'b0;
    end

    // A fetch completes only once the registered read request is actually on the bus,
    // so the first cycle after reset release cannot consume a stale mem_ready.
    assign fetch_ack_s = (state_r == S_FETCH) & ctrl_r.memread & bus.mem_ready;

    // Next-state, next opcode latch and MULT countdown.
    always_comb begin
        state_next_s = state_r;
        op_q_next_s  = op_q_r;
        count_next_s = count_r;
        case (state_r)
            S_FETCH: begin
                if (fetch_ack_s) begin
                    state_next_s = S_DECODE;
                end else begin
                    state_next_s = S_FETCH;
                end
            end
            S_DECODE: begin
                op_q_next_s = bus.op[3:0];
                if (op_hi_s) begin
                    state_next_s = S_FETCH;
                end else begin
                    case (bus.op[3:0])
                        4'h0:       state_next_s = S_FETCH;
                        4'h1, 4'h2: state_next_s = S_JUMP;
                        4'h3, 4'h4: state_next_s = S_BRANCH;
                        4'h7, 4'h8: state_next_s = S_MEMADR;
                        4'hD: begin
                            state_next_s = S_MULT;
                            count_next_s = CW'(MULT_CYCLES - 1);
                        end
                        default:    state_next_s = S_EXEC;
                    endcase
                end
            end
            S_EXEC:   state_next_s = S_RWB;
            S_RWB:    state_next_s = S_FETCH;
            S_MEMADR: state_next_s = S_MEM;
            S_MEM: begin
                if (!bus.mem_ready) begin
                    state_next_s = S_MEM;
                end else if (op_q_r == 4'h7) begin
                    state_next_s = S_LWB;
                end else begin
                    state_next_s = S_FETCH;
                end
            end
            S_LWB:    state_next_s = S_FETCH;
            S_BRANCH: state_next_s = S_FETCH;
            S_JUMP:   state_next_s = S_FETCH;
            S_MULT: begin
                if (count_r == '0) begin
                    state_next_s = S_FETCH;
                end else begin
                    count_next_s = count_r - CW'(1);
                end
            end
            default:  state_next_s = S_FETCH;
        endcase
    end

    // State, opcode and counter registers; control outputs are registered from the
    // next state so they stay exactly aligned with state_r.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= S_FETCH;
            op_q_r  <= 4'h0;
            count_r <= '0;
            ctrl_r  <= '0;
        end else begin
            state_r <= state_next_s;
            op_q_r  <= op_q_next_s;
            count_r <= count_next_s;
            ctrl_r  <= moore_ctrl(state_next_s, op_q_next_s, (count_next_s == '0));
        end
    end

    assign bus.memread  = ctrl_r.memread;
    assign bus.memwrite = ctrl_r.memwrite;
    assign pcwrite      = ctrl_r.pcwrite | fetch_ack_s;
    assign irwrite      = fetch_ack_s;
    assign regwrite     = ctrl_r.regwrite;
    assign regdst       = ctrl_r.regdst;
    assign alusrc       = ctrl_r.alusrc;
    assign mem2reg      = ctrl_r.mem2reg;
    assign branch       = ctrl_r.branch;
    assign jump         = ctrl_r.jump;
    assign jumpreg      = ctrl_r.jumpreg;
    assign hilo_sel     = ctrl_r.hilo_sel;
    assign hilo_write   = ctrl_r.hilo_write;
    assign busy         = ctrl_r.busy;
    assign illegal      = (state_r == S_DECODE) & op_hi_s;
    assign state_o      = state_r;
endmodule

// File: tb/tb_multicycle_maindec.sv
// Scoreboard bench for multicycle_maindec: each stimulus cycle queues the hand-computed
// state/output vector, and a negedge monitor pops and compares it against the DUT.
module tb_multicycle_maindec;
    localparam logic [3:0] SF = 4'd0, SD = 4'd1, SE = 4'd2, SW = 4'd3, SA = 4'd4,
                           SM = 4'd5, SL = 4'd6, SB = 4'd7, SJ = 4'd8, SU = 4'd9;

    localparam logic [15:0] ILL = 16'h0001, BSY = 16'h0002, HW = 16'h0004,
                            HHI = 16'h0008, HLO = 16'h0010, JR = 16'h0020,
                            JI = 16'h0040, BR = 16'h0080, M2R = 16'h0100,
                            MW = 16'h0200, MR = 16'h0400, ASR = 16'h0800,
                            RDS = 16'h1000, RW = 16'h2000, IRW = 16'h4000,
                            PCW = 16'h8000;

    typedef struct {
        logic [19:0] v;
        string       nm;
    } exp_t;

    logic clk = 1'b1;
    logic reset;
    logic pcwrite, irwrite, regwrite, regdst, alusrc, mem2reg, branch, jump, jumpreg;
    logic [1:0] hilo_sel;
    logic hilo_write, busy, illegal;
    logic [3:0] state_o;
    logic [19:0] obs;
    exp_t exp_q[$];
    int checks = 0;
    int failures = 0;

    multicycle_maindec_if #(.OPW(6)) bus ();

    multicycle_maindec #(.OPW(6), .MULT_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .pcwrite(pcwrite), .irwrite(irwrite), .regwrite(regwrite), .regdst(regdst),
        .alusrc(alusrc), .mem2reg(mem2reg), .branch(branch), .jump(jump),
        .jumpreg(jumpreg), .hilo_sel(hilo_sel), .hilo_write(hilo_write),
        .busy(busy), .illegal(illegal), .state_o(state_o)
    );

    always #5 clk = ~clk;

    assign obs = {state_o, pcwrite, irwrite, regwrite, regdst, alusrc, bus.memread,
                  bus.memwrite, mem2reg, branch, jump, jumpreg, hilo_sel, hilo_write,
                  busy, illegal};

    // Monitor: pop the expectation for this cycle and compare mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (obs !== e.v) begin
                failures++;
                $display("FAIL %s: got state=%0d ctl=%h, expected state=%0d ctl=%h",
                         e.nm, obs[19:16], obs[15:0], e.v[19:16], e.v[15:0]);
            end
        end
    end

    task automatic step(input logic [5:0] o, input logic mr, input logic [3:0] st,
                        input logic [15:0] bits, input string nm);
        exp_t e;
        bus.op        = o;
        bus.mem_ready = mr;
        e.v           = {st, bits};
        e.nm          = nm;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset         = 1'b0;
        bus.op        = 6'd0;
        bus.mem_ready = 1'b1;
        #1;
        step(6'd0, 1'b1, SF, 16'h0, "rst_hold0");
        step(6'd0, 1'b1, SF, 16'h0, "rst_hold1");
        reset = 1'b1;
        step(6'd0, 1'b1, SF, 16'h0, "rel_first");

        // ADD
        step(6'h09, 1'b1, SF, MR | IRW | PCW, "add_fetch");
        step(6'h09, 1'b1, SD, BSY,            "add_decode");
        step(6'h09, 1'b1, SE, BSY | RDS,      "add_exec");
        step(6'h09, 1'b1, SW, BSY | RDS | RW, "add_rwb");

        // LW with three wait cycles in S_MEM
        step(6'h07, 1'b1, SF, MR | IRW | PCW,  "lw_fetch");
        step(6'h07, 1'b1, SD, BSY,             "lw_decode");
        step(6'h07, 1'b0, SA, BSY | ASR,       "lw_memadr");
        step(6'h07, 1'b0, SM, BSY | ASR | MR,  "lw_mem_wait1");
        step(6'h07, 1'b0, SM, BSY | ASR | MR,  "lw_mem_wait2");
        step(6'h07, 1'b0, SM, BSY | ASR | MR,  "lw_mem_wait3");
        step(6'h07, 1'b1, SM, BSY | ASR | MR,  "lw_mem_done");
        step(6'h07, 1'b1, SL, BSY | RW | M2R,  "lw_wb");

        // SW
        step(6'h08, 1'b1, SF, MR | IRW | PCW,  "sw_fetch");
        step(6'h08, 1'b1, SD, BSY,             "sw_decode");
        step(6'h08, 1'b1, SA, BSY | ASR,       "sw_memadr");
        step(6'h08, 1'b1, SM, BSY | ASR | MW,  "sw_mem");

        // MULT: four S_MULT cycles, hilo_write on the last
        step(6'h0D, 1'b1, SF, MR | IRW | PCW, "mult_fetch");
        step(6'h0D, 1'b1, SD, BSY,            "mult_decode");
        step(6'h0D, 1'b1, SU, BSY,            "mult_c1");
        step(6'h0D, 1'b1, SU, BSY,            "mult_c2");
        step(6'h0D, 1'b1, SU, BSY,            "mult_c3");
        step(6'h0D, 1'b1, SU, BSY | HW,       "mult_c4");

        // Reset in the middle of a MULT
        step(6'h0D, 1'b1, SF, MR | IRW | PCW, "mrst_fetch");
        step(6'h0D, 1'b1, SD, BSY,            "mrst_decode");
        step(6'h0D, 1'b1, SU, BSY,            "mrst_c1");
        reset = 1'b0;
        step(6'h0D, 1'b1, SF, 16'h0, "mrst_low0");
        step(6'h0D, 1'b1, SF, 16'h0, "mrst_low1");
        reset = 1'b1;
        step(6'h0D, 1'b1, SF, 16'h0, "mrst_rel");
        step(6'h00, 1'b0, SF, MR,    "mrst_fetch_wait");

        // JR then JI
        step(6'h01, 1'b1, SF, MR | IRW | PCW, "jr_fetch");
        step(6'h01, 1'b1, SD, BSY,            "jr_decode");
        step(6'h01, 1'b1, SJ, BSY | PCW | JR, "jr_jump");
        step(6'h02, 1'b1, SF, MR | IRW | PCW, "ji_fetch");
        step(6'h02, 1'b1, SD, BSY,            "ji_decode");
        step(6'h02, 1'b1, SJ, BSY | PCW | JI, "ji_jump");

        // BE
        step(6'h03, 1'b1, SF, MR | IRW | PCW, "be_fetch");
        step(6'h03, 1'b1, SD, BSY,            "be_decode");
        step(6'h03, 1'b1, SB, BSY | BR,       "be_branch");

        // MFHI and MFLO select
        step(6'h05, 1'b1, SF, MR | IRW | PCW,       "mfhi_fetch");
        step(6'h05, 1'b1, SD, BSY,                  "mfhi_decode");
        step(6'h05, 1'b1, SE, BSY | RDS | HHI,      "mfhi_exec");
        step(6'h05, 1'b1, SW, BSY | RDS | RW | HHI, "mfhi_rwb");
        step(6'h06, 1'b1, SF, MR | IRW | PCW,       "mflo_fetch");
        step(6'h06, 1'b1, SD, BSY,                  "mflo_decode");
        step(6'h06, 1'b1, SE, BSY | RDS | HLO,      "mflo_exec");
        step(6'h06, 1'b1, SW, BSY | RDS | RW | HLO, "mflo_rwb");

        // Illegal opcode with nonzero upper bits
        step(6'b010011, 1'b1, SF, MR | IRW | PCW, "ill_fetch");
        step(6'b010011, 1'b1, SD, BSY | ILL,      "ill_decode");
        step(6'b000000, 1'b0, SF, MR,             "ill_next");

        // NOOP
        step(6'h00, 1'b1, SF, MR | IRW | PCW, "noop_fetch");
        step(6'h00, 1'b1, SD, BSY,            "noop_decode");
        step(6'h00, 1'b0, SF, MR,             "noop_next");

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
